// File: rtl/clk_enable_pkg.sv
// Shared types and standard increment constants for the clock-enable generator.
// The increments assume a 50 MHz sys clock and a 32-bit phase accumulator.
package clk_enable_pkg;

   typedef enum logic [1:0] {
      WAIT_LOCK = 2'd0,
      HOLD      = 2'd1,
      RUN       = 2'd2
   } lock_state_e;

   // Each constant is round(rate / 50 MHz * 2^32).
   localparam logic [31:0] PIT_INC_50MHZ         = 32'd102493553;
   localparam logic [31:0] UART_115200_INC_50MHZ = 32'd9895605;
   localparam logic [31:0] UART_9600_INC_50MHZ   = 32'd824634;
   localparam logic [31:0] TICK_1KHZ_INC_50MHZ   = 32'd85899;

endpackage

// File: rtl/clk_enable_gen_frac_accum.sv
// One fractional phase accumulator: the carry out of acc + inc becomes a
// one-cycle registered enable strobe.
module frac_accum #(
   parameter int ACC_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 clear,
   input  logic                 run,
   input  logic [ACC_WIDTH-1:0] inc,
   output logic                 tick
);

   logic [ACC_WIDTH:0]   sum_s;
   logic [ACC_WIDTH-1:0] acc_d, acc_q;
   logic                 tick_d, tick_q;

   always_comb begin
      sum_s = {1'b0, acc_q} + {1'b0, inc};
      if (clear || !run) begin
         acc_d  = '0;
         tick_d = 1'b0;
      end else begin
         // Keep the remainder so the long-term rate is exact.
         acc_d  = sum_s[ACC_WIDTH-1:0];
         tick_d = sum_s[ACC_WIDTH];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         acc_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         acc_q  <= acc_d;
         tick_q <= tick_d;
      end
   end

   assign tick = tick_q;

endmodule

// File: rtl/clk_enable_gen.sv
// Lock-gated bank of programmable clock-enable strobes derived from the sys clock.
// Holds the lock synchroniser, holdoff FSM and increment register file.
module clk_enable_gen
   import clk_enable_pkg::*;
#(
   parameter  int                          NUM_CH      = 4,
   parameter  int                          ACC_WIDTH   = 32,
   parameter  logic [NUM_CH*ACC_WIDTH-1:0] DEFAULT_INC = '0,
   parameter  int                          HOLDOFF     = 1024,
   localparam int                          CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 pll_locked,
   input  logic                 inc_wr_en,
   input  logic [CH_W-1:0]      inc_wr_ch,
   input  logic [ACC_WIDTH-1:0] inc_wr_data,
   input  logic [NUM_CH-1:0]    ch_en,
   output logic [NUM_CH-1:0]    tick,
   output logic                 ready
);

   localparam int CNT_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

   lock_state_e          state_d, state_q;
   logic [CNT_W-1:0]     cnt_d, cnt_q;
   logic                 lock_meta_d, lock_meta_q;
   logic                 lock_s_d, lock_s_q;
   logic                 ready_d, ready_q;
   logic [ACC_WIDTH-1:0] inc_d [NUM_CH];
   logic [ACC_WIDTH-1:0] inc_q [NUM_CH];

   always_comb begin
      lock_meta_d = pll_locked;
      lock_s_d    = lock_meta_q;
      state_d     = state_q;
      cnt_d       = cnt_q;
      case (state_q)
         WAIT_LOCK: begin
            cnt_d = '0;
            if (lock_s_q) begin
               state_d = HOLD;
            end else begin
               state_d = WAIT_LOCK;
            end
         end
         HOLD: begin
            if (!lock_s_q) begin
               state_d = WAIT_LOCK;
            end else if (cnt_q == CNT_W'(HOLDOFF - 1)) begin
               state_d = RUN;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         RUN: begin
            if (!lock_s_q) begin
               state_d = WAIT_LOCK;
            end else begin
               state_d = RUN;
            end
         end
         default: begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
         end
      endcase
      ready_d = (state_d == RUN);
   end

   // Out-of-range channel indices match no entry, so such writes fall away.
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         if (inc_wr_en && (inc_wr_ch == CH_W'(i))) begin
            inc_d[i] = inc_wr_data;
         end else begin
            inc_d[i] = inc_q[i];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= WAIT_LOCK;
         cnt_q       <= '0;
         lock_meta_q <= 1'b0;
         lock_s_q    <= 1'b0;
         ready_q     <= 1'b0;
         for (int i = 0; i < NUM_CH; i++) begin
            inc_q[i] <= DEFAULT_INC[i*ACC_WIDTH +: ACC_WIDTH];
         end
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         lock_meta_q <= lock_meta_d;
         lock_s_q    <= lock_s_d;
         ready_q     <= ready_d;
         for (int i = 0; i < NUM_CH; i++) begin
            inc_q[i] <= inc_d[i];
         end
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      frac_accum #(
         .ACC_WIDTH (ACC_WIDTH)
      ) u_accum (
         .clk   (clk),
         .reset (reset),
         .clear (!ready_q),
         .run   (ch_en[g]),
         .inc   (inc_q[g]),
         .tick  (tick[g])
      );
   end

   assign ready = ready_q;

endmodule

// File: tb/tb_clk_enable_gen.sv
// Scoreboard bench for clk_enable_gen: a rate/phase model predicts ready and tick
// per clock, a negedge monitor compares against the DUT.
module tb_clk_enable_gen;

   // Three channels so that channel index 3 is representable but out of range.
   localparam int              NCH     = 3;
   localparam int              W       = 8;
   localparam int              HOLDOFF = 4;
   localparam logic [NCH*W-1:0] DEF    = {8'd33, 8'd20, 8'd10};

   logic           clk = 1'b0;
   logic           reset;
   logic           pll_locked;
   logic           inc_wr_en;
   logic [1:0]     inc_wr_ch;
   logic [W-1:0]   inc_wr_data;
   logic [NCH-1:0] ch_en;
   logic [NCH-1:0] tick;
   logic           ready;

   clk_enable_gen #(
      .NUM_CH      (NCH),
      .ACC_WIDTH   (W),
      .DEFAULT_INC (DEF),
      .HOLDOFF     (HOLDOFF)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .pll_locked  (pll_locked),
      .inc_wr_en   (inc_wr_en),
      .inc_wr_ch   (inc_wr_ch),
      .inc_wr_data (inc_wr_data),
      .ch_en       (ch_en),
      .tick        (tick),
      .ready       (ready)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic           rdy;
      logic [NCH-1:0] tk;
      bit             win;
   } exp_t;

   exp_t sb_q[$];
   int   vectors     = 0;
   int   miscompares = 0;
   int   win_ticks   = 0;
   bit   win         = 1'b0;

   // Reference model state: phase per channel, increments, lock history.
   int             m_acc [NCH];
   int             m_inc [NCH];
   logic [NCH-1:0] m_tick;
   bit             m_lk1, m_lk2, m_ready;
   int             m_run;
   logic [NCH*W-1:0] def_v;

   // Predict the outputs after the coming edge from the inputs now applied.
   task automatic step();
      exp_t e;
      int   sum;
      bit   lock_s;
      if (reset) begin
         for (int c = 0; c < NCH; c++) begin
            m_acc[c] = 0;
            m_inc[c] = int'(def_v[c*W +: W]);
         end
         m_tick  = '0;
         m_lk1   = 1'b0;
         m_lk2   = 1'b0;
         m_run   = 0;
         m_ready = 1'b0;
      end else begin
         lock_s = m_lk2;
         for (int c = 0; c < NCH; c++) begin
            if (m_ready && ch_en[c]) begin
               sum       = m_acc[c] + m_inc[c];
               m_tick[c] = (sum >= (1 << W));
               m_acc[c]  = sum % (1 << W);
            end else begin
               m_tick[c] = 1'b0;
               m_acc[c]  = 0;
            end
         end
         if (inc_wr_en && (int'(inc_wr_ch) < NCH)) m_inc[inc_wr_ch] = int'(inc_wr_data);
         // Ready needs HOLDOFF+1 consecutive synchronised lock samples.
         m_run   = lock_s ? m_run + 1 : 0;
         m_ready = (m_run >= HOLDOFF + 1);
         m_lk2   = m_lk1;
         m_lk1   = pll_locked;
      end
      e.rdy = m_ready;
      e.tk  = m_tick;
      e.win = win;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input int ch, input int data);
      inc_wr_en   = 1'b1;
      inc_wr_ch   = 2'(ch);
      inc_wr_data = W'(data);
      step();
      inc_wr_en   = 1'b0;
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         vectors++;
         if ((ready !== e.rdy) || (tick !== e.tk)) begin
            miscompares++;
            $display("FAIL outputs t=%0t: ready=%b tick=%b, expected ready=%b tick=%b",
                     $time, ready, tick, e.rdy, e.tk);
         end
         if (e.win && tick[1]) win_ticks++;
      end
   end

   initial begin
      def_v       = DEF;
      reset       = 1'b1;
      pll_locked  = 1'b0;
      inc_wr_en   = 1'b0;
      inc_wr_ch   = 2'd0;
      inc_wr_data = '0;
      ch_en       = '0;
      repeat (2) step();
      reset = 1'b0;
      repeat (3) step();

      wr(0, 64);
      ch_en      = 3'b001;
      pll_locked = 1'b1;
      repeat (20) step();

      // 96/256 gives 3 ticks per 8 cycles: exactly 300 in any 800-cycle window.
      wr(1, 96);
      ch_en = 3'b011;
      win   = 1'b1;
      repeat (800) step();
      win   = 1'b0;
      step();
      @(negedge clk);
      #1;
      vectors++;
      if (win_ticks != 300) begin
         miscompares++;
         $display("FAIL rate96: %0d ticks on ch1 in 800 cycles, expected 300", win_ticks);
      end

      // Phase-continuous rate change taken while channel 0 sits at acc=128.
      for (int k = 0; k < 8 && m_acc[0] != 128; k++) step();
      wr(0, 128);
      repeat (20) step();

      pll_locked = 1'b0;
      step();
      pll_locked = 1'b1;
      repeat (15) step();

      ch_en = 3'b111;
      wr(3, 200);
      repeat (10) step();

      wr(0, 0);
      wr(1, 255);
      repeat (600) step();

      reset = 1'b1;
      step();
      reset = 1'b0;
      repeat (30) step();

      repeat (1500) begin
         pll_locked = ($urandom_range(0, 99) < 3) ? 1'b0 : 1'b1;
         reset      = ($urandom_range(0, 499) == 0);
         inc_wr_en  = ($urandom_range(0, 9) == 0);
         inc_wr_ch  = 2'($urandom_range(0, 3));
         case ($urandom_range(0, 2))
            0:       inc_wr_data = W'(0);
            1:       inc_wr_data = W'(255);
            default: inc_wr_data = W'($urandom);
         endcase
         if ($urandom_range(0, 19) == 0) ch_en = NCH'($urandom);
         step();
      end
      reset      = 1'b0;
      inc_wr_en  = 1'b0;
      pll_locked = 1'b1;
      repeat (4) step();
      @(negedge clk);
      #1;
      vectors++;
      if (sb_q.size() != 0) begin
         miscompares++;
         $display("FAIL drain: %0d expected entries left unchecked, expected 0", sb_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
